// File: rtl/alu_iterative_pkg.sv
// alu_iterative_pkg: opcodes, FSM states and datapath defaults shared by the ALU and the decoder
package alu_iterative_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int SHAMT_W_DEF = 5;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SLL = 4'd2;
  localparam logic [3:0] ALU_SLT = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_OR = 4'd8;
  localparam logic [3:0] ALU_AND = 4'd9;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
  function automatic logic is_shift(input logic [3:0] op);
    return op == ALU_SLL || op == ALU_SRL || op == ALU_SRA;
  endfunction
endpackage

// File: rtl/alu_comb.sv
// alu_comb: single-cycle ALU ops; shifts and illegal codes give 0 here
module alu_comb
  import alu_iterative_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  logic slt, sltu;
  assign slt = $signed(a) < $signed(b);
  assign sltu = a < b;
  // single-cycle result select
  always_comb begin
    y = op == ALU_ADD  ? a + b :
        op == ALU_SUB  ? a - b :
        op == ALU_SLT  ? {{(WIDTH-1){1'b0}}, slt} :
        op == ALU_SLTU ? {{(WIDTH-1){1'b0}}, sltu} :
        op == ALU_XOR  ? a ^ b :
        op == ALU_OR   ? a | b :
        op == ALU_AND  ? a & b : '0;
  end
endmodule

// File: rtl/alu_iterative.sv
// alu_iterative: execute-stage ALU with single-cycle logic ops and bit-serial shifts
module alu_iterative
  import alu_iterative_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, acc_sh, result_q, result_d, comb_y;
  logic [SHAMT_W-1:0] cnt_q, cnt_d, shamt;
  logic [3:0] op_q, op_d;
  logic done_q, done_d, zero_q;
  alu_comb #(.WIDTH(WIDTH)) u_comb (.op(alu_op), .a(a), .b(b), .y(comb_y));
  assign shamt = b[SHAMT_W-1:0];
  assign busy = state_q == ST_SHIFT;
  assign done = done_q;
  assign result = result_q;
  assign zero = zero_q;
  // next state: accept in IDLE, step the shift one bit per clock in SHIFT
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    op_d = op_q;
    done_d = 1'b0;
    result_d = result_q;
    acc_sh = op_q == ALU_SLL ? acc_q << 1 :
             op_q == ALU_SRA ? {acc_q[WIDTH-1], acc_q[WIDTH-1:1]} : acc_q >> 1;
    if (state_q == ST_IDLE) begin
      if (start && is_shift(alu_op) && shamt != '0) begin
        state_d = ST_SHIFT;
        acc_d = a;
        cnt_d = shamt;
        op_d = alu_op;
      end else if (start) begin
        result_d = is_shift(alu_op) ? a : comb_y;
        done_d = 1'b1;
      end
    end else begin
      acc_d = acc_sh;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == SHAMT_W'(1)) begin
        state_d = ST_IDLE;
        result_d = acc_sh;
        done_d = 1'b1;
      end
    end
  end
  // state and output registers; reset aborts any shift in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      op_q <= ALU_ADD;
      done_q <= 1'b0;
      result_q <= '0;
      zero_q <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      done_q <= done_d;
      result_q <= result_d;
      zero_q <= ~|result_d;
    end
  end
endmodule
